// File: rtl/sodor_dmem_bridge.sv
// Data-memory bridge: Sodor core io_dmem port to a word-wide handshaked memory bus.
// One access outstanding. Sub-word stores are lane-replicated with a byte mask, and
// sub-word loads are lane-extracted and extended. Misaligned accesses and bus timeouts
// complete with an error flag, so the core never hangs.
module sodor_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_dmem_req_valid,
  input  logic [31:0] io_dmem_req_bits_addr,
  input  logic [31:0] io_dmem_req_bits_data,
  input  logic        io_dmem_req_bits_fcn,
  input  logic [2:0]  io_dmem_req_bits_typ,
  output logic        io_dmem_resp_valid,
  output logic [31:0] io_dmem_resp_bits_data,
  output logic        io_dmem_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [3:0]  mem_req_wmask,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam logic [2:0] TypB  = 3'd1;
  localparam logic [2:0] TypH  = 3'd2;
  localparam logic [2:0] TypBu = 3'd5;
  localparam logic [2:0] TypHu = 3'd6;
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e      r_state;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_typ;
  logic        r_fcn;
  logic [7:0]  r_cnt;

  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_resp_err;
  logic        r_mem_req_valid;
  logic [31:0] r_mem_req_addr;
  logic        r_mem_req_wen;
  logic [3:0]  r_mem_req_wmask;
  logic [31:0] r_mem_req_wdata;

  logic        w_is_b;
  logic        w_is_h;
  logic        w_is_w;
  logic        w_misaligned;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_sh;
  logic [31:0] w_load;

  // Decode the incoming request: access size, alignment and store formatting.
  always_comb begin
    w_is_b = (io_dmem_req_bits_typ == TypB) || (io_dmem_req_bits_typ == TypBu);
    w_is_h = (io_dmem_req_bits_typ == TypH) || (io_dmem_req_bits_typ == TypHu);
    // Unknown type codes fall through to a full word.
    w_is_w = !(w_is_b || w_is_h);
    w_misaligned = (w_is_h && io_dmem_req_bits_addr[0]) ||
                   (w_is_w && (io_dmem_req_bits_addr[1:0] != 2'b00));
    w_wmask = 4'b0000;
    w_wdata = 32'h0;
    if (io_dmem_req_bits_fcn) begin
      if (w_is_b) begin
        w_wmask = 4'b0001 << io_dmem_req_bits_addr[1:0];
        w_wdata = {4{io_dmem_req_bits_data[7:0]}};
      end else if (w_is_h) begin
        w_wmask = 4'b0011 << {io_dmem_req_bits_addr[1], 1'b0};
        w_wdata = {2{io_dmem_req_bits_data[15:0]}};
      end else begin
        w_wmask = 4'b1111;
        w_wdata = io_dmem_req_bits_data;
      end
    end
  end

  // Shift the returned word down to the addressed lane and extend it.
  always_comb begin
    w_sh = mem_resp_data >> {r_addr_lo, 3'b000};
    unique case (r_typ)
      TypB:    w_load = {{24{w_sh[7]}}, w_sh[7:0]};
      TypBu:   w_load = {24'h0, w_sh[7:0]};
      TypH:    w_load = {{16{w_sh[15]}}, w_sh[15:0]};
      TypHu:   w_load = {16'h0, w_sh[15:0]};
      default: w_load = w_sh;
    endcase
  end

  // Access sequencer with registered core-side and bus-side outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= StIdle;
      r_addr_lo       <= 2'b00;
      r_typ           <= 3'd0;
      r_fcn           <= 1'b0;
      r_cnt           <= 8'd0;
      r_resp_valid    <= 1'b0;
      r_resp_data     <= 32'h0;
      r_resp_err      <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= 32'h0;
      r_mem_req_wen   <= 1'b0;
      r_mem_req_wmask <= 4'b0000;
      r_mem_req_wdata <= 32'h0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_dmem_req_valid) begin
            r_addr_lo <= io_dmem_req_bits_addr[1:0];
            r_typ     <= io_dmem_req_bits_typ;
            r_fcn     <= io_dmem_req_bits_fcn;
            if (w_misaligned) begin
              // Complete immediately with an error; the bus never sees it.
              r_state      <= StDone;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= 32'h0;
            end else begin
              r_state         <= StIssue;
              r_mem_req_valid <= 1'b1;
              r_mem_req_addr  <= {io_dmem_req_bits_addr[31:2], 2'b00};
              r_mem_req_wen   <= io_dmem_req_bits_fcn;
              r_mem_req_wmask <= w_wmask;
              r_mem_req_wdata <= w_wdata;
            end
          end
        end
        StIssue: begin
          if (mem_req_ready) begin
            r_state         <= StWait;
            r_cnt           <= 8'd0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= 32'h0;
            r_mem_req_wen   <= 1'b0;
            r_mem_req_wmask <= 4'b0000;
            r_mem_req_wdata <= 32'h0;
          end
        end
        StWait: begin
          if (mem_resp_valid) begin
            r_state      <= StDone;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_data  <= r_fcn ? 32'h0 : w_load;
          end else if (r_cnt == TimeoutCnt) begin
            r_state      <= StDone;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_data  <= 32'h0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StDone: begin
          // The held core request is not resampled until the next IDLE cycle.
          r_state      <= StIdle;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_data  <= 32'h0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_dmem_resp_valid     = r_resp_valid;
  assign io_dmem_resp_bits_data = r_resp_data;
  assign io_dmem_resp_err       = r_resp_err;
  assign mem_req_valid          = r_mem_req_valid;
  assign mem_req_addr           = r_mem_req_addr;
  assign mem_req_wen            = r_mem_req_wen;
  assign mem_req_wmask          = r_mem_req_wmask;
  assign mem_req_wdata          = r_mem_req_wdata;

endmodule

// File: doc/sodor_dmem_bridge.md
# sodor_dmem_bridge

Data-memory bridge between the single-cycle Sodor core's `io_dmem` port and a word-wide, handshaked backing memory bus. It accepts one core load/store at a time, handles sub-word stores (lane replication and byte mask) and sub-word loads (lane extraction with sign/zero extension), and returns a one-cycle `io_dmem_resp_valid` pulse. The core's data path stalls on `dmiss` until that pulse. The bridge also detects misaligned accesses and bus timeouts and reports them without hanging the core.

## Interface
Parameters
- `TIMEOUT_CYCLES`, default 255: cycles spent in WAIT before an access is aborted with an error; 8-bit counter.

Ports
- `clock`  in  1  sole clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `io_dmem_req_valid`  in  1  core request; held high while the core is stalled
- `io_dmem_req_bits_addr`  in  32  byte address
- `io_dmem_req_bits_data`  in  32  store data, right-aligned
- `io_dmem_req_bits_fcn`  in  1  0 = read, 1 = write
- `io_dmem_req_bits_typ`  in  3  1 = B, 2 = H, 3 = W, 5 = BU, 6 = HU; any other value is treated as W
- `io_dmem_resp_valid`  out  1  one-cycle completion pulse
- `io_dmem_resp_bits_data`  out  32  load result, extended; 0 on writes and on errors
- `io_dmem_resp_err`  out  1  qualifies `io_dmem_resp_valid`: the access was misaligned or timed out
- `mem_req_valid`  out  1  bus request
- `mem_req_ready`  in  1  bus accepts when `mem_req_valid & mem_req_ready`
- `mem_req_addr`  out  32  word address; `addr[1:0]` forced to 0
- `mem_req_wen`  out  1  write enable
- `mem_req_wmask`  out  4  byte-lane enables
- `mem_req_wdata`  out  32  lane-replicated store data
- `mem_resp_valid`  in  1  bus completion, used for both reads and writes
- `mem_resp_data`  in  32  read word

## Operation
- States: IDLE, ISSUE, WAIT, DONE. On reset, state goes to IDLE and every output is 0.
- **IDLE**
  - When `io_dmem_req_valid=1`, latch addr, data, fcn and typ.
  - If the access is misaligned (H/HU with `addr[0]=1`, or W with `addr[1:0]!=0`), go to DONE with err=1. No bus request is made.
  - Otherwise go to ISSUE.
- **ISSUE**
  - Drive `mem_req_valid=1` from registered fields.
  - On `mem_req_ready=1`, go to WAIT and clear the timeout counter.
  - Request fields stay stable until accepted.
- **WAIT**
  - `mem_req_valid=0`.
  - On `mem_resp_valid=1`, capture the formatted result and go to DONE with err=0.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES`, go to DONE with err=1.
- **DONE**
  - Assert `io_dmem_resp_valid=1` for exactly one cycle, together with data and err, then go to IDLE.
  - In IDLE, `io_dmem_req_valid` is sampled only from the cycle after DONE, so the held request is never reissued.
- Store formatting
  - Data: B/BU → `{4{d[7:0]}}`; H/HU → `{2{d[15:0]}}`; W → `d`.
  - Mask: B → `4'b0001 << a[1:0]`; H → `4'b0011 << {a[1],1'b0}`; W → `4'b1111`.
  - For reads, wmask = 0 and wdata = 0.
- Load formatting
  - Shift: `sh = mem_resp_data >> (a[1:0]*8)`.
  - Extend: B → sign-extend `sh[7:0]`; BU → zero-extend `sh[7:0]`; H → sign-extend `sh[15:0]`; HU → zero-extend `sh[15:0]`; W → `sh`.
- Ignored inputs
  - `mem_resp_valid` is ignored outside WAIT, including in the acceptance cycle and after a timeout.
  - A late response arriving after a timeout is dropped.
- Reset mid-operation
  - Reset aborts immediately.
  - Any bus response outstanding at reset is ignored, since the bridge is in IDLE.

## Timing
- Aligned access, zero-wait bus (ready=1, response one cycle after acceptance):
  - cycle 0: request sampled
  - cycle 1: ISSUE, accepted
  - cycle 2: WAIT, response
  - cycle 3: `io_dmem_resp_valid`
  - Minimum latency is 3 cycles.
- Each cycle `mem_req_ready` stays low adds one cycle. Each cycle of response delay adds one cycle.
- Misaligned access: response at cycle 1.
- Timeout: `io_dmem_resp_valid` 1 + k + `TIMEOUT_CYCLES` + 1 cycles after sampling, where k is the number of ISSUE cycles.
- All outputs are registered or derived from state only. There are no combinational paths from core inputs to bus outputs.
- Throughput is one access outstanding. Back-to-back accesses are spaced by DONE→IDLE, giving ≥4 cycles per access.

## Test plan
- **Word load:** read W at 0x100, bus returns 0x8899AABB after 1 cycle → `resp_valid` at cycle 3, data 0x8899AABB, err 0; `mem_req_addr` 0x100, wen 0.
- **Sub-word loads** (bus word 0x8899AABB at 0x100):
  - B at 0x101 → 0xFFFFFFAA
  - BU at 0x103 → 0x00000088
  - H at 0x102 → 0xFFFF8899
  - HU at 0x100 → 0x0000AABB
- **Stores:**
  - SB data 0x12345678 at 0x203 → `mem_req_addr` 0x200, wmask 4'b1000, wdata 0x78787878
  - SH at 0x202 → wmask 4'b1100, wdata 0x56785678
  - After the bus ack, `resp_valid` pulses once with data 0.
- **Misaligned:** LW at 0x102 → no `mem_req_valid` ever; `resp_valid` and err at cycle 1.
- **Backpressure and timeout:**
  - With ready low for 5 cycles, request fields hold stable; `resp_valid` arrives at cycle 8.
  - With `TIMEOUT_CYCLES`=4 and no response → err=1. A late `mem_resp_valid` afterward produces no extra pulse.
- **Held request and reset:**
  - The core keeps `req_valid` high through DONE → exactly one bus request is issued per access.
  - Asserting `reset` low during WAIT → all outputs drop to 0 asynchronously. The bus response that follows is ignored, and the next request is handled normally.
